// File: rtl/keynsham_arb_pkg.sv
// -----------------------------------------------------------------------------
// keynsham_arb_pkg
// Shared types for the keynsham memory arbiter: the requester index, the
// sequencer state, and the request record that a slot captures and the
// arbiter forwards to the 32-bit bridge.
// -----------------------------------------------------------------------------
package keynsham_arb_pkg;

  // Requester index; PORT_NONE means no grant is outstanding.
  typedef enum logic [1:0] {
    PORT_D    = 2'd0,
    PORT_X    = 2'd1,
    PORT_I    = 2'd2,
    PORT_NONE = 2'd3
  } port_e;

  // Sequencer state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // One bridge request as captured from a requester.
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        wr_en;
    logic [3:0]  bytesel;
  } req_t;

  localparam logic [3:0] ALL_BYTES = 4'b1111;

  // Instruction fetches are always full-word reads, so the request is built
  // here from the address alone; nothing from the other ports can leak in.
  function automatic req_t ifetch_req(input logic [29:0] addr);
    req_t r;
    r.addr    = addr;
    r.wdata   = 32'h0000_0000;
    r.wr_en   = 1'b0;
    r.bytesel = ALL_BYTES;
    return r;
  endfunction

endpackage

// File: rtl/arb_req_slot.sv
// -----------------------------------------------------------------------------
// arb_req_slot
// Single-entry holding register for one requester.
//   clk_i, rst_i : clock, synchronous active-high reset
//   access_i     : request pulse, req_i valid in the same cycle
//   req_i        : request fields to capture
//   clear_i      : the arbiter has completed this slot's request
//   pending_o    : slot holds a request not yet completed
//   req_o        : captured request fields
// -----------------------------------------------------------------------------
module arb_req_slot
  import keynsham_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic access_i,
  input  req_t req_i,
  input  logic clear_i,
  output logic pending_o,
  output req_t req_o
);

  logic pending_q, pending_d;
  req_t req_q, req_d;
  logic capture_s;

  // A clear frees the slot on the same edge, so a new access arriving with
  // the clear is accepted; an access while still pending is dropped.
  assign capture_s = access_i && (!pending_q || clear_i);

  // Next-state for the pending flag and stored request.
  always_comb begin
    pending_d = pending_q;
    req_d     = req_q;
    if (capture_s) begin
      pending_d = 1'b1;
      req_d     = req_i;
    end else if (clear_i) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Slot registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      req_q     <= '0;
    end else begin
      pending_q <= pending_d;
      req_q     <= req_d;
    end
  end

  assign pending_o = pending_q;
  assign req_o     = req_q;

endmodule

// File: rtl/keynsham_mem_arbiter.sv
// -----------------------------------------------------------------------------
// keynsham_mem_arbiter
// Three-requester arbiter/sequencer in front of the 32-bit host side of the
// SDRAM 32->16 bridge. Requests are held in per-port slots and issued one at
// a time; priority is d > x > i, except that the instruction port is forced
// after STARVE_LIMIT consecutive d/x grants taken while it was waiting.
//   clk, rst            : clock, synchronous active-high reset
//   d_* / x_*           : data / DMA request (access pulse, addr, wdata,
//                         wr_en, bytesel) and registered ack/read data
//   i_*                 : instruction fetch request (read-only) and ack/data
//   m_cs..m_bytesel     : registered bridge request, held until m_compl
//   m_rdata, m_compl    : bridge read data and completion pulse
// -----------------------------------------------------------------------------
module keynsham_mem_arbiter
  import keynsham_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_access,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wr_val,
  input  logic        d_wr_en,
  input  logic [3:0]  d_bytesel,
  output logic        d_ack,
  output logic [31:0] d_data,
  input  logic        x_access,
  input  logic [29:0] x_addr,
  input  logic [31:0] x_wr_val,
  input  logic        x_wr_en,
  input  logic [3:0]  x_bytesel,
  output logic        x_ack,
  output logic [31:0] x_data,
  input  logic        i_access,
  input  logic [29:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_data,
  output logic        m_cs,
  output logic [29:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_wr_en,
  output logic [3:0]  m_bytesel,
  input  logic [31:0] m_rdata,
  input  logic        m_compl
);

  state_e            state_q;
  port_e             grant_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  req_t d_in_s, x_in_s, i_in_s;
  req_t d_slot_s, x_slot_s, i_slot_s;
  logic d_pend_s, x_pend_s, i_pend_s;
  logic d_clr_s, x_clr_s, i_clr_s;
  logic compl_s, starve_s;
  port_e sel_s;
  req_t  sel_req_s;

  assign d_in_s = '{addr: d_addr, wdata: d_wr_val, wr_en: d_wr_en, bytesel: d_bytesel};
  assign x_in_s = '{addr: x_addr, wdata: x_wr_val, wr_en: x_wr_en, bytesel: x_bytesel};
  assign i_in_s = ifetch_req(i_addr);

  // A completion only counts while a grant is outstanding; late pulses in
  // IDLE (e.g. after a reset abandoned the grant) fall through.
  assign compl_s = (state_q == ST_BUSY) && m_compl;
  assign d_clr_s = compl_s && (grant_q == PORT_D);
  assign x_clr_s = compl_s && (grant_q == PORT_X);
  assign i_clr_s = compl_s && (grant_q == PORT_I);

  arb_req_slot u_slot_d (
    .clk_i(clk), .rst_i(rst), .access_i(d_access), .req_i(d_in_s),
    .clear_i(d_clr_s), .pending_o(d_pend_s), .req_o(d_slot_s)
  );

  arb_req_slot u_slot_x (
    .clk_i(clk), .rst_i(rst), .access_i(x_access), .req_i(x_in_s),
    .clear_i(x_clr_s), .pending_o(x_pend_s), .req_o(x_slot_s)
  );

  arb_req_slot u_slot_i (
    .clk_i(clk), .rst_i(rst), .access_i(i_access), .req_i(i_in_s),
    .clear_i(i_clr_s), .pending_o(i_pend_s), .req_o(i_slot_s)
  );

  assign starve_s = i_pend_s && (cnt_q >= CNT_W'(STARVE_LIMIT));

  // Port selection: forced instruction grant first, then fixed d > x > i.
  always_comb begin
    sel_s = PORT_NONE;
    if (starve_s) begin
      sel_s = PORT_I;
    end else if (d_pend_s) begin
      sel_s = PORT_D;
    end else if (x_pend_s) begin
      sel_s = PORT_X;
    end else if (i_pend_s) begin
      sel_s = PORT_I;
    end else begin
      sel_s = PORT_NONE;
    end
  end

  // Request fields of the selected slot.
  always_comb begin
    sel_req_s = '0;
    case (sel_s)
      PORT_D:  sel_req_s = d_slot_s;
      PORT_X:  sel_req_s = x_slot_s;
      PORT_I:  sel_req_s = i_slot_s;
      default: sel_req_s = '0;
    endcase
  end

  // Starvation count, applied only when a grant is actually issued.
  always_comb begin
    cnt_d = cnt_q;
    if ((sel_s == PORT_D) || (sel_s == PORT_X)) begin
      if (!i_pend_s) begin
        cnt_d = '0;
      end else if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (sel_s == PORT_I) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Sequencer FSM with registered bridge request and ack/data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= PORT_NONE;
      cnt_q     <= '0;
      m_cs      <= 1'b0;
      m_addr    <= 30'h0;
      m_wdata   <= 32'h0;
      m_wr_en   <= 1'b0;
      m_bytesel <= 4'h0;
      d_ack     <= 1'b0;
      x_ack     <= 1'b0;
      i_ack     <= 1'b0;
      d_data    <= 32'h0;
      x_data    <= 32'h0;
      i_data    <= 32'h0;
    end else begin
      // Acks are single-cycle pulses; data reads as zero without an ack.
      d_ack  <= 1'b0;
      x_ack  <= 1'b0;
      i_ack  <= 1'b0;
      d_data <= 32'h0;
      x_data <= 32'h0;
      i_data <= 32'h0;
      case (state_q)
        ST_IDLE: begin
          if (sel_s != PORT_NONE) begin
            grant_q   <= sel_s;
            cnt_q     <= cnt_d;
            m_cs      <= 1'b1;
            m_addr    <= sel_req_s.addr;
            m_wdata   <= sel_req_s.wdata;
            m_wr_en   <= sel_req_s.wr_en;
            m_bytesel <= sel_req_s.bytesel;
            state_q   <= ST_BUSY;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (m_compl) begin
            m_cs    <= 1'b0;
            grant_q <= PORT_NONE;
            state_q <= ST_IDLE;
            case (grant_q)
              PORT_D: begin
                d_ack  <= 1'b1;
                d_data <= m_rdata;
              end
              PORT_X: begin
                x_ack  <= 1'b1;
                x_data <= m_rdata;
              end
              PORT_I: begin
                i_ack  <= 1'b1;
                i_data <= m_rdata;
              end
              default: begin
                d_ack <= 1'b0;
              end
            endcase
          end else begin
            state_q <= ST_BUSY;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= PORT_NONE;
          m_cs    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keynsham_mem_arbiter.sv
module tb_keynsham_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_access, x_access, i_access;
  logic [29:0] d_addr, x_addr, i_addr;
  logic [31:0] d_wr_val, x_wr_val;
  logic        d_wr_en, x_wr_en;
  logic [3:0]  d_bytesel, x_bytesel;
  logic        d_ack, x_ack, i_ack;
  logic [31:0] d_data, x_data, i_data;
  logic        m_cs, m_wr_en, m_compl;
  logic [29:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_bytesel;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        wr_en;
    logic [3:0]  bs;
  } txn_t;

  typedef struct {
    int          port;
    logic [31:0] data;
  } ack_t;

  txn_t exp_txn[$];
  ack_t exp_ack[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic bridge_en = 1'b1;
  int   late_req  = 0;

  keynsham_mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .d_access(d_access), .d_addr(d_addr), .d_wr_val(d_wr_val), .d_wr_en(d_wr_en),
    .d_bytesel(d_bytesel), .d_ack(d_ack), .d_data(d_data),
    .x_access(x_access), .x_addr(x_addr), .x_wr_val(x_wr_val), .x_wr_en(x_wr_en),
    .x_bytesel(x_bytesel), .x_ack(x_ack), .x_data(x_data),
    .i_access(i_access), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data),
    .m_cs(m_cs), .m_addr(m_addr), .m_wdata(m_wdata), .m_wr_en(m_wr_en),
    .m_bytesel(m_bytesel), .m_rdata(m_rdata), .m_compl(m_compl)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Bridge model: completes 3 cycles after m_cs rises, rdata = addr ^ 0xDEADBFEF.
  initial begin
    int lat;
    int late_done;
    lat = 0;
    late_done = 0;
    m_compl = 1'b0;
    m_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (m_compl) begin
        m_compl = 1'b0;
        m_rdata = 32'h0;
        lat = 0;
      end else if (late_req != late_done) begin
        m_compl = 1'b1;
        m_rdata = 32'hBAD0_BAD0;
        late_done = late_req;
      end else if (m_cs && bridge_en) begin
        lat++;
        if (lat == 3) begin
          m_compl = 1'b1;
          m_rdata = {2'b00, m_addr} ^ 32'hDEAD_BFEF;
          lat = 0;
        end
      end else begin
        lat = 0;
      end
    end
  end

  // Monitor: pops expected transactions on m_cs rise and expected acks on ack.
  initial begin
    logic prev_cs;
    txn_t cur;
    txn_t t;
    ack_t a;
    int   nacks;
    int   port;
    logic [31:0] data;
    prev_cs = 1'b0;
    cur = '{addr: 30'h0, wdata: 32'h0, wr_en: 1'b0, bs: 4'h0};
    forever begin
      @(negedge clk);
      nacks = int'(d_ack) + int'(x_ack) + int'(i_ack);
      check("ack_onehot", {63'h0, nacks <= 1}, 64'd1);
      if (!d_ack) check("d_data_idle", {32'h0, d_data}, 64'h0);
      if (!x_ack) check("x_data_idle", {32'h0, x_data}, 64'h0);
      if (!i_ack) check("i_data_idle", {32'h0, i_data}, 64'h0);
      if (nacks > 0) begin
        port = d_ack ? 0 : (x_ack ? 1 : 2);
        data = d_ack ? d_data : (x_ack ? x_data : i_data);
        if (exp_ack.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ack_unexpected: got port %0d data %0h expected none", port, data);
        end else begin
          a = exp_ack.pop_front();
          check("ack_port", 64'(port), 64'(a.port));
          check("ack_data", {32'h0, data}, {32'h0, a.data});
        end
      end
      if (m_cs && !prev_cs) begin
        if (exp_txn.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL txn_unexpected: got addr %0h expected none", m_addr);
        end else begin
          t = exp_txn.pop_front();
          cur = t;
          check("txn_addr", {34'h0, m_addr}, {34'h0, t.addr});
          check("txn_wdata", {32'h0, m_wdata}, {32'h0, t.wdata});
          check("txn_wr_en", {63'h0, m_wr_en}, {63'h0, t.wr_en});
          check("txn_bytesel", {60'h0, m_bytesel}, {60'h0, t.bs});
        end
      end else if (m_cs && prev_cs) begin
        check("txn_stable", {m_addr, m_wr_en, m_bytesel, 29'h0}, {cur.addr, cur.wr_en, cur.bs, 29'h0});
        check("txn_stable_wdata", {32'h0, m_wdata}, {32'h0, cur.wdata});
      end
      prev_cs = m_cs;
    end
  end

  task automatic push_txn(input logic [29:0] addr, input logic [31:0] wd, input logic we, input logic [3:0] bs);
    txn_t t;
    t.addr = addr; t.wdata = wd; t.wr_en = we; t.bs = bs;
    exp_txn.push_back(t);
  endtask

  task automatic push_ack(input int port, input logic [31:0] data);
    ack_t a;
    a.port = port; a.data = data;
    exp_ack.push_back(a);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, {58'h0, m_cs, m_wr_en, d_ack, x_ack, i_ack, |m_bytesel}, 64'h0);
    check({tag, "_addr"}, {34'h0, m_addr}, 64'h0);
    check({tag, "_wdata"}, {32'h0, m_wdata}, 64'h0);
    check({tag, "_data"}, {32'h0, d_data | x_data | i_data}, 64'h0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_txn.size() != 0 || exp_ack.size() != 0 || m_cs) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d txns/%0d acks outstanding expected 0", tag, exp_txn.size(), exp_ack.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    d_access = 1'b0; x_access = 1'b0; i_access = 1'b0;
    d_addr = '0; x_addr = '0; i_addr = '0;
    d_wr_val = '0; x_wr_val = '0; d_wr_en = 1'b0; x_wr_en = 1'b0;
    d_bytesel = 4'h0; x_bytesel = 4'h0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single read from d.
    push_txn(30'h100, 32'h0, 1'b0, 4'hF);
    push_ack(0, 32'hDEAD_BEEF);
    d_access = 1'b1; d_addr = 30'h100; d_wr_val = 32'h0; d_wr_en = 1'b0; d_bytesel = 4'hF;
    @(negedge clk);
    d_access = 1'b0;
    check("t1_cs_after_capture", {63'h0, m_cs}, 64'h0);
    @(negedge clk);
    check("t1_cs_granted", {63'h0, m_cs}, 64'h1);
    wait_idle("t1");

    // Simultaneous access on all three ports.
    push_txn(30'h10, 32'hAAAA_0010, 1'b0, 4'hF);
    push_txn(30'h20, 32'hBBBB_0020, 1'b1, 4'h3);
    push_txn(30'h30, 32'h0, 1'b0, 4'hF);
    push_ack(0, 32'hDEAD_BFFF);
    push_ack(1, 32'hDEAD_BFCF);
    push_ack(2, 32'hDEAD_BFDF);
    d_access = 1'b1; d_addr = 30'h10; d_wr_val = 32'hAAAA_0010; d_wr_en = 1'b0; d_bytesel = 4'hF;
    x_access = 1'b1; x_addr = 30'h20; x_wr_val = 32'hBBBB_0020; x_wr_en = 1'b1; x_bytesel = 4'h3;
    i_access = 1'b1; i_addr = 30'h30;
    @(negedge clk);
    d_access = 1'b0; x_access = 1'b0; i_access = 1'b0;
    wait_idle("t2");

    // Starvation: d and x keep requesting while i waits; i is the 5th grant.
    for (int k = 0; k < 4; k++) push_txn(30'h40, 32'h4040_4040, 1'b0, 4'hF);
    push_txn(30'h60, 32'h0, 1'b0, 4'hF);
    push_txn(30'h40, 32'h4040_4040, 1'b0, 4'hF);
    push_txn(30'h50, 32'h5050_5050, 1'b0, 4'hF);
    for (int k = 0; k < 4; k++) push_ack(0, 32'hDEAD_BFAF);
    push_ack(2, 32'hDEAD_BF8F);
    push_ack(0, 32'hDEAD_BFAF);
    push_ack(1, 32'hDEAD_BFBF);
    d_access = 1'b1; d_addr = 30'h40; d_wr_val = 32'h4040_4040; d_wr_en = 1'b0; d_bytesel = 4'hF;
    x_access = 1'b1; x_addr = 30'h50; x_wr_val = 32'h5050_5050; x_wr_en = 1'b0; x_bytesel = 4'hF;
    i_access = 1'b1; i_addr = 30'h60;
    @(negedge clk);
    i_access = 1'b0;
    n = 0;
    while (!(m_cs && m_addr == 30'h60) && n < 300) begin
      @(negedge clk);
      n++;
    end
    d_access = 1'b0; x_access = 1'b0;
    check("t3_i_grant_seen", {63'h0, n < 300}, 64'h1);
    check("t3_cnt_cleared", 64'(dut.cnt_q), 64'h0);
    wait_idle("t3");

    // Instruction grant while d inputs carry stale write fields.
    push_txn(30'h74, 32'h0, 1'b0, 4'hF);
    push_ack(2, 32'hDEAD_BF9B);
    d_addr = 30'h70; d_wr_val = 32'hFFFF_FFFF; d_wr_en = 1'b1; d_bytesel = 4'b0001;
    i_access = 1'b1; i_addr = 30'h74;
    @(negedge clk);
    i_access = 1'b0;
    wait_idle("t4");

    // Write followed by a protocol-violating second access.
    push_txn(30'h80, 32'h1234_5678, 1'b1, 4'b0011);
    push_ack(0, 32'hDEAD_BF6F);
    d_access = 1'b1; d_addr = 30'h80; d_wr_val = 32'h1234_5678; d_wr_en = 1'b1; d_bytesel = 4'b0011;
    @(negedge clk);
    d_addr = 30'h999; d_wr_val = 32'h0; d_wr_en = 1'b0; d_bytesel = 4'hF;
    @(negedge clk);
    d_access = 1'b0;
    wait_idle("t5");
    repeat (6) @(negedge clk);

    // Reset mid-BUSY, then a late completion.
    bridge_en = 1'b0;
    push_txn(30'h200, 32'h55, 1'b1, 4'hF);
    x_access = 1'b1; x_addr = 30'h200; x_wr_val = 32'h55; x_wr_en = 1'b1; x_bytesel = 4'hF;
    @(negedge clk);
    x_access = 1'b0;
    n = 0;
    while (!m_cs && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_busy_reached", {63'h0, m_cs}, 64'h1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs_zero("t6_reset");
    late_req = late_req + 1;
    repeat (4) @(negedge clk);
    check_outputs_zero("t6_late");
    bridge_en = 1'b1;
    push_txn(30'h210, 32'h0, 1'b0, 4'hF);
    push_ack(1, 32'hDEAD_BDFF);
    x_access = 1'b1; x_addr = 30'h210; x_wr_val = 32'h0; x_wr_en = 1'b0; x_bytesel = 4'hF;
    @(negedge clk);
    x_access = 1'b0;
    wait_idle("t6");

    repeat (10) @(negedge clk);
    check("txn_queue_empty", 64'(exp_txn.size()), 64'h0);
    check("ack_queue_empty", 64'(exp_ack.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
